md_engine: RTL and testbench

- Iterative multiply/divide execution unit for the MIPS EX stage; executes mult, multu, div and divu.
- Delivers a 64-bit {hi, lo} result with a one-cycle done pulse to the HI/LO register holder downstream, which writes HI/LO on done.
- Drives busy, which the hazard unit uses to stall any following mult/div/mfhi/mflo/mthi/mtlo.

---
 rtl/md_engine.sv | 126 ++++++++++++
 tb/tb_md_engine.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/md_engine.sv
// Iterative multiply/divide unit for the EX stage: mult/multu in MULT_LAT cycles,
// div/divu by 32-step restoring division plus one sign/zero fixup cycle.
module md_engine #(
  parameter int unsigned MULT_LAT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] prod;
  logic [31:0] rem;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] a_sav;
  logic        div_zero;
  logic        neg_q;
  logic        neg_r;

  logic        is_sdiv;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [31:0] rem_lo;
  logic        rem_ge;
  logic [31:0] rem_sub;

  always_comb begin
    is_sdiv = (op == 2'b10);
    a_mag   = (is_sdiv && a[31]) ? -a : a;
    b_mag   = (is_sdiv && b[31]) ? -b : b;
    ext_a   = op[0] ? {32'b0, a} : {{32{a[31]}}, a};
    ext_b   = op[0] ? {32'b0, b} : {{32{b[31]}}, b};
    // Shifted remainder is 33 bits wide; rem[31] acts as its top bit so the
    // subtraction itself fits in 32 bits whenever it is taken.
    rem_lo  = {rem[30:0], dvd[31]};
    rem_ge  = rem[31] | (rem_lo >= dvs);
    rem_sub = rem_lo - dvs;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      prod     <= '0;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      a_sav    <= '0;
      div_zero <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (!op[1]) begin
              prod  <= ext_a * ext_b;
              cnt   <= 5'(MULT_LAT - 1);
              state <= MUL;
            end else begin
              rem      <= '0;
              dvd      <= a_mag;
              dvs      <= b_mag;
              a_sav    <= a;
              div_zero <= (b == '0);
              neg_q    <= is_sdiv && (a[31] ^ b[31]);
              neg_r    <= is_sdiv && a[31];
              cnt      <= 5'd31;
              state    <= DIV;
            end
          end
        end
        MUL: begin
          if (cnt == '0) begin
            hi    <= prod[63:32];
            lo    <= prod[31:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DIV: begin
          rem <= rem_ge ? rem_sub : rem_lo;
          dvd <= {dvd[30:0], rem_ge};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 5'd1;
        end
        FIX: begin
          if (div_zero) begin
            lo <= '1;
            hi <= a_sav;
          end else begin
            lo <= neg_q ? -dvd : dvd;
            hi <= neg_r ? -rem : rem;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_engine.sv
// Self-checking bench for md_engine: directed vectors, randomized ops against
// an arithmetic reference model, start-while-busy and mid-operation reset.
module tb_md_engine;

  localparam int unsigned MULT_LAT = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int passed = 0;
  int total  = 0;

  md_engine #(.MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: res = 64'(sx * sy);
      2'b01: res = {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 0) res = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) res = {x, 32'hFFFFFFFF};
        else res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
    return o[1] ? 33 : int'(MULT_LAT);
  endfunction

  // Issues one op and waits (bounded) for busy to drop; returns observations.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output bit done_in_busy,
                       output logic d, output logic [31:0] h, output logic [31:0] l);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    lat = 0;
    done_in_busy = 1'b0;
    while (busy === 1'b1 && lat < 200) begin
      lat++;
      if (done !== 1'b0) done_in_busy = 1'b1;
      @(negedge clk);
    end
    d = done; h = hi; l = lo;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({busy, done} !== 2'b00) $display("FAIL reset_flags busy/done=%b required 00", {busy, done}); else passed++;
    total++; if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo got %h required 0", {hi, lo}); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [1:0]  ops [8] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2};
    logic [31:0] as  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'h00000007, 32'h80000000, 32'h00000007, 32'hFFFFFFF9};
    logic [31:0] bs  [8] = '{32'hFFFFFFFF, 32'h00000003, 32'h00000002, 32'h00000002,
                             32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000000};
    logic [31:0] ehi [8] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,
                             32'h00000007, 32'h00000000, 32'h00000001, 32'hFFFFFFF9};
    logic [31:0] elo [8] = '{32'h00000001, 32'hFFFFFFFA, 32'hFFFFFFFD, 32'h7FFFFFFC,
                             32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFF};
    int lat; bit dib; logic d; logic [31:0] h, l;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i], lat, dib, d, h, l);
      total++; if (lat != exp_lat(ops[i])) $display("FAIL dir%0d_latency got %0d required %0d", i, lat, exp_lat(ops[i])); else passed++;
      total++; if (dib) $display("FAIL dir%0d_done_while_busy got 1 required 0", i); else passed++;
      total++; if (d !== 1'b1) $display("FAIL dir%0d_done_pulse got %b required 1", i, d); else passed++;
      total++; if (h !== ehi[i]) $display("FAIL dir%0d_hi got %h required %h", i, h, ehi[i]); else passed++;
      total++; if (l !== elo[i]) $display("FAIL dir%0d_lo got %h required %h", i, l, elo[i]); else passed++;
      @(negedge clk);
      total++; if (done !== 1'b0) $display("FAIL dir%0d_done_width got %b required 0", i, done); else passed++;
    end
  endtask

  task automatic test_random;
    int lat; bit dib; logic d; logic [31:0] h, l, x, y; logic [1:0] o; logic [63:0] e;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = 32'($urandom_range(1, 15));
        2: x = 32'h80000000;
        3: y = 32'hFFFFFFFF;
        default: ;
      endcase
      e = model(o, x, y);
      issue(o, x, y, lat, dib, d, h, l);
      total++; if (lat != exp_lat(o) || dib || d !== 1'b1)
        $display("FAIL rnd%0d_timing lat=%0d dib=%0b done=%b required lat=%0d dib=0 done=1", i, lat, dib, d, exp_lat(o));
      else passed++;
      total++; if ({h, l} !== e)
        $display("FAIL rnd%0d_result op=%0d a=%h b=%h got %h required %h", i, o, x, y, {h, l}, e);
      else passed++;
      repeat (3) @(negedge clk);
      total++; if ({hi, lo} !== e || busy !== 1'b0)
        $display("FAIL rnd%0d_hold got %h busy=%b required %h busy=0", i, {hi, lo}, busy, e);
      else passed++;
    end
  endtask

  task automatic test_start_while_busy;
    int n = 0;
    int dn = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (done === 1'b1) dn++;
      op = 2'($urandom); a = $urandom; b = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    total++; if (n != 33) $display("FAIL swb_latency got %0d required 33", n); else passed++;
    total++; if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL swb_result got %h required %h", {hi, lo}, {32'd2, 32'd14}); else passed++;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    total++; if (dn != 1) $display("FAIL swb_done_count got %0d required 1", dn); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL swb_idle_after got busy=%b required 0", busy); else passed++;
  endtask

  task automatic test_reset_mid_op;
    int dn = 0;
    int lat; bit dib; logic d; logic [31:0] h, l;
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'h12345678; b = 32'h00000013;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL rst_mid_busy_before got %b required 1", busy); else passed++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if ({busy, done} !== 2'b00 || {hi, lo} !== 64'h0)
      $display("FAIL rst_mid_clear busy=%b done=%b hilo=%h required 0 0 0", busy, done, {hi, lo});
    else passed++;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) dn++;
      @(negedge clk);
    end
    total++; if (dn != 0) $display("FAIL rst_mid_quiet got %0d active cycles required 0", dn); else passed++;
    issue(2'b01, 32'd3, 32'd4, lat, dib, d, h, l);
    total++; if (lat != int'(MULT_LAT) || d !== 1'b1) $display("FAIL rst_mid_mul_timing lat=%0d done=%b required %0d 1", lat, d, MULT_LAT); else passed++;
    total++; if ({h, l} !== 64'hC) $display("FAIL rst_mid_mul_result got %h required %h", {h, l}, 64'hC); else passed++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_start_while_busy;
    test_reset_mid_op;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
